// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and constants for the Ethernet RX frame FIFO
package eth_pkg;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } wr_state_e;

  localparam int STAT_WIDTH = 32;

  function automatic int keep_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/eth_fifo_ram.sv
// rtl/eth_fifo_ram.sv - simple dual-port RAM, sync write, registered read that holds when idle
module eth_fifo_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// rtl/eth_rx_frame_fifo.sv - store-and-forward Ethernet RX frame FIFO with bad/overflow frame drop
// Defining ETH_RX_FIFO_STATS_EN adds saturating good/bad/overflow frame counters.
module eth_rx_frame_fifo
  import eth_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4096,
  localparam int KEEP_WIDTH = keep_width(DATA_WIDTH),
  localparam int PTR_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  good_frame,
  output logic                  bad_frame,
  output logic                  overflow,
  output logic [PTR_WIDTH-1:0]  occupancy
`ifdef ETH_RX_FIFO_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_good,
  output logic [STAT_WIDTH-1:0] stat_bad,
  output logic [STAT_WIDTH-1:0] stat_overflow
`endif
);

  localparam int WORD_W = DATA_WIDTH + KEEP_WIDTH + 1;

  wr_state_e            state_q, state_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d, ready_q;
  logic                 beat, full, wr_en, rd_en, pop;
  logic [PTR_WIDTH-1:0] fetch_ptr;
  logic [WORD_W-1:0]    rd_word;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    good_d       = 1'b0;
    bad_d        = 1'b0;
    ovf_d        = 1'b0;
    wr_en        = 1'b0;
    beat         = s_axis_tvalid & ready_q;
    full         = (wr_ptr_q - rd_ptr_q) == PTR_WIDTH'(DEPTH);
    if (beat) begin
      case (state_q)
        ST_ACCEPT: begin
          if (full) begin
            wr_ptr_d = commit_ptr_q;
            ovf_d    = 1'b1;
            if (!s_axis_tlast) state_d = ST_DROP;
          end else if (s_axis_tlast && s_axis_tuser) begin
            wr_ptr_d = commit_ptr_q;
            bad_d    = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
            if (s_axis_tlast) begin
              commit_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
              good_d       = 1'b1;
            end
          end
        end
        default: if (s_axis_tlast) state_d = ST_ACCEPT;
      endcase
    end
  end

  // The RAM read register doubles as the output register; it only reloads when empty or popped.
  always_comb begin
    pop         = out_valid_q & m_axis_tready;
    fetch_ptr   = rd_ptr_q + PTR_WIDTH'(out_valid_q);
    rd_en       = (fetch_ptr != commit_ptr_q) && (!out_valid_q || pop);
    out_valid_d = rd_en | (out_valid_q & ~pop);
    rd_ptr_d    = rd_ptr_q + PTR_WIDTH'(pop);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      good_q       <= 1'b0;
      bad_q        <= 1'b0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      ovf_q        <= ovf_d;
      out_valid_q  <= out_valid_d;
      ready_q      <= 1'b1;
    end
  end

  eth_fifo_ram #(
    .WIDTH     (WORD_W),
    .ADDR_WIDTH(PTR_WIDTH - 1)
  ) u_ram (
    .clock  (clock),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr_q[PTR_WIDTH-2:0]),
    .wr_data({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .rd_en  (rd_en),
    .rd_addr(fetch_ptr[PTR_WIDTH-2:0]),
    .rd_data(rd_word)
  );

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_word;
  assign m_axis_tvalid = out_valid_q;
  assign s_axis_tready = ready_q;
  assign good_frame    = good_q;
  assign bad_frame     = bad_q;
  assign overflow      = ovf_q;
  assign occupancy     = commit_ptr_q - rd_ptr_q;

`ifdef ETH_RX_FIFO_STATS_EN
  logic [STAT_WIDTH-1:0] stat_good_q, stat_good_d, stat_bad_q, stat_bad_d, stat_ovf_q, stat_ovf_d;

  always_comb begin
    stat_good_d = stat_good_q;
    stat_bad_d  = stat_bad_q;
    stat_ovf_d  = stat_ovf_q;
    if (good_q && stat_good_q != '1) stat_good_d = stat_good_q + STAT_WIDTH'(1);
    if (bad_q  && stat_bad_q  != '1) stat_bad_d  = stat_bad_q  + STAT_WIDTH'(1);
    if (ovf_q  && stat_ovf_q  != '1) stat_ovf_d  = stat_ovf_q  + STAT_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stat_good_q <= '0;
      stat_bad_q  <= '0;
      stat_ovf_q  <= '0;
    end else begin
      stat_good_q <= stat_good_d;
      stat_bad_q  <= stat_bad_d;
      stat_ovf_q  <= stat_ovf_d;
    end
  end

  assign stat_good     = stat_good_q;
  assign stat_bad      = stat_bad_q;
  assign stat_overflow = stat_ovf_q;
`endif

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb/tb_eth_rx_frame_fifo.sv - self-checking bench: 8-bit/4096 and 32-bit/16 instances, scoreboarded output
module tb_eth_rx_frame_fifo;

  logic        clk;
  logic        reset_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast, s_tuser, tvalid_a, tvalid_b, m_tready;

  logic        s_tready_a, m_tvalid_a, m_tlast_a, good_a, bad_a, ovf_a;
  logic [7:0]  m_tdata_a;
  logic [0:0]  m_tkeep_a;
  logic [12:0] occ_a;
  logic        s_tready_b, m_tvalid_b, m_tlast_b, good_b, bad_b, ovf_b;
  logic [31:0] m_tdata_b;
  logic [3:0]  m_tkeep_b;
  logic [4:0]  occ_b;
`ifdef ETH_RX_FIFO_STATS_EN
  logic [31:0] st_good_a, st_bad_a, st_ovf_a, st_good_b, st_bad_b, st_ovf_b;
`endif

  eth_rx_frame_fifo #(.DATA_WIDTH(8), .DEPTH(4096)) dut_a (
    .clock(clk), .reset_n(reset_n),
    .s_axis_tdata(s_tdata[7:0]), .s_axis_tkeep(s_tkeep[0:0]), .s_axis_tvalid(tvalid_a),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready_a),
    .m_axis_tdata(m_tdata_a), .m_axis_tkeep(m_tkeep_a), .m_axis_tvalid(m_tvalid_a),
    .m_axis_tlast(m_tlast_a), .m_axis_tready(m_tready),
    .good_frame(good_a), .bad_frame(bad_a), .overflow(ovf_a), .occupancy(occ_a)
`ifdef ETH_RX_FIFO_STATS_EN
    , .stat_good(st_good_a), .stat_bad(st_bad_a), .stat_overflow(st_ovf_a)
`endif
  );

  eth_rx_frame_fifo #(.DATA_WIDTH(32), .DEPTH(16)) dut_b (
    .clock(clk), .reset_n(reset_n),
    .s_axis_tdata(s_tdata[31:0]), .s_axis_tkeep(s_tkeep[3:0]), .s_axis_tvalid(tvalid_b),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready_b),
    .m_axis_tdata(m_tdata_b), .m_axis_tkeep(m_tkeep_b), .m_axis_tvalid(m_tvalid_b),
    .m_axis_tlast(m_tlast_b), .m_axis_tready(m_tready),
    .good_frame(good_b), .bad_frame(bad_b), .overflow(ovf_b), .occupancy(occ_b)
`ifdef ETH_RX_FIFO_STATS_EN
    , .stat_good(st_good_b), .stat_bad(st_bad_b), .stat_overflow(st_ovf_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } word_t;

  typedef struct {
    int sel;
    int nbytes;
    bit tuser;
    int exp_good;
    int exp_bad;
    int exp_ovf;
    int exp_occ;
  } vec_t;

  word_t sb_a[$];
  word_t sb_b[$];
  vec_t  vecs[7];
  int    total = 0;
  int    bad = 0;
  int    good_cnt[2] = '{0, 0};
  int    bad_cnt[2] = '{0, 0};
  int    ovf_cnt[2] = '{0, 0};
  int    cur_beat = 0;
  int    ovf_beat = -1;
  bit    stall_a = 1'b0, stall_b = 1'b0;
  logic [10:0] held_a;
  logic [37:0] held_b;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard pops, stall-hold checks and event-pulse counting, sampled away from the active edge.
  always @(negedge clk) begin
    word_t w;
    if (!reset_n) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (good_a) good_cnt[0]++;
      if (bad_a)  bad_cnt[0]++;
      if (ovf_a)  ovf_cnt[0]++;
      if (good_b) good_cnt[1]++;
      if (bad_b)  bad_cnt[1]++;
      if (ovf_b) begin ovf_cnt[1]++; ovf_beat = cur_beat - 1; end
      if (stall_a) chk("stall_hold_a", {53'd0, held_a}, {53'd0, m_tvalid_a, m_tdata_a, m_tkeep_a, m_tlast_a});
      if (stall_b) chk("stall_hold_b", {26'd0, held_b}, {26'd0, m_tvalid_b, m_tdata_b, m_tkeep_b, m_tlast_b});
      if (m_tvalid_a && m_tready) begin
        if (sb_a.size() == 0) chk("unexpected_word_a", {55'd0, m_tdata_a, m_tlast_a}, 64'hDEAD);
        else begin
          w = sb_a.pop_front();
          chk("data_a", {54'd0, m_tdata_a, m_tkeep_a, m_tlast_a}, {54'd0, w.data[7:0], w.keep[0], w.last});
        end
      end
      if (m_tvalid_b && m_tready) begin
        if (sb_b.size() == 0) chk("unexpected_word_b", {31'd0, m_tdata_b, m_tlast_b}, 64'hDEAD);
        else begin
          w = sb_b.pop_front();
          chk("data_b", {27'd0, m_tdata_b, m_tkeep_b, m_tlast_b}, {27'd0, w.data[31:0], w.keep[3:0], w.last});
        end
      end
      stall_a = m_tvalid_a && !m_tready;
      stall_b = m_tvalid_b && !m_tready;
      held_a  = {m_tvalid_a, m_tdata_a, m_tkeep_a, m_tlast_a};
      held_b  = {m_tvalid_b, m_tdata_b, m_tkeep_b, m_tlast_b};
    end
  end

  // Drives nsend beats of an nbytes frame (little-endian lanes); pushes expected words when push=1.
  task automatic send_frame(input int sel, input int nbytes, input bit tuser, input int seed,
                            input bit push, input int nsend);
    int bpb = (sel == 0) ? 1 : 4;
    int nbeats = (nbytes + bpb - 1) / bpb;
    word_t w;
    for (int k = 0; k < nbeats && k < nsend; k++) begin
      @(posedge clk); #1;
      w.data = '0;
      w.keep = '0;
      for (int j = 0; j < bpb; j++) begin
        if (k * bpb + j < nbytes) begin
          w.data[8*j +: 8] = 8'(seed + k * bpb + j);
          w.keep[j] = 1'b1;
        end
      end
      w.last   = (k == nbeats - 1);
      s_tdata  = w.data;
      s_tkeep  = w.keep;
      s_tlast  = w.last;
      s_tuser  = w.last & tuser;
      tvalid_a = (sel == 0);
      tvalid_b = (sel == 1);
      cur_beat = k + 1;
      if (push) begin
        if (sel == 0) sb_a.push_back(w);
        else sb_b.push_back(w);
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    tvalid_a = 1'b0;
    tvalid_b = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    m_tready = 1'b1;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_left", 64'(sb_a.size() + sb_b.size()), 64'd0);
    chk("tvalid_idle", {62'd0, m_tvalid_a, m_tvalid_b}, 64'd0);
  endtask

  initial begin
    int g0, b0, o0;
    //            sel bytes tuser good bad ovf occ
    vecs[0] = '{0, 64, 1'b0, 1, 0, 0, 64};
    vecs[1] = '{0, 64, 1'b1, 0, 1, 0, 0};
    vecs[2] = '{0, 60, 1'b0, 1, 0, 0, 60};
    vecs[3] = '{1, 80, 1'b0, 0, 0, 1, 0};
    vecs[4] = '{1, 32, 1'b0, 1, 0, 0, 8};
    vecs[5] = '{1, 61, 1'b0, 1, 0, 0, 16};
    vecs[6] = '{0, 1,  1'b0, 1, 0, 0, 1};

    reset_n = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0;
    tvalid_a = 1'b0; tvalid_b = 1'b0; m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", {62'd0, m_tvalid_a, m_tvalid_b}, 64'd0);
    chk("reset_occ", {46'd0, occ_a, occ_b}, 64'd0);
    chk("reset_pulses", {58'd0, good_a, bad_a, ovf_a, good_b, bad_b, ovf_b}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("tready_after_reset", {62'd0, s_tready_a, s_tready_b}, 64'd3);

    for (int i = 0; i < 7; i++) begin
      m_tready = 1'b0;
      g0 = good_cnt[vecs[i].sel];
      b0 = bad_cnt[vecs[i].sel];
      o0 = ovf_cnt[vecs[i].sel];
      send_frame(vecs[i].sel, vecs[i].nbytes, vecs[i].tuser, 16 * i + 3, vecs[i].exp_good != 0, 1000);
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("good_pulses_%0d", i), 64'(good_cnt[vecs[i].sel] - g0), 64'(vecs[i].exp_good));
      chk($sformatf("bad_pulses_%0d", i), 64'(bad_cnt[vecs[i].sel] - b0), 64'(vecs[i].exp_bad));
      chk($sformatf("ovf_pulses_%0d", i), 64'(ovf_cnt[vecs[i].sel] - o0), 64'(vecs[i].exp_ovf));
      chk($sformatf("occupancy_%0d", i), (vecs[i].sel == 0) ? 64'(occ_a) : 64'(occ_b), 64'(vecs[i].exp_occ));
      if (vecs[i].exp_ovf != 0) chk("ovf_at_beat", 64'(ovf_beat), 64'd17);
      wait_drain();
    end

    // Three back-to-back frames with the consumer stalling every other cycle.
    m_tready = 1'b0;
    fork
      begin
        send_frame(0, 20, 1'b0, 101, 1'b1, 1000);
        send_frame(0, 33, 1'b0, 131, 1'b1, 1000);
        send_frame(0, 7,  1'b0, 171, 1'b1, 1000);
        idle();
      end
      begin
        repeat (400) begin
          @(posedge clk); #1;
          m_tready = ~m_tready;
        end
      end
    join
    wait_drain();

    // Reset while one frame is committed and another is half received.
    m_tready = 1'b0;
    send_frame(0, 10, 1'b0, 200, 1'b0, 1000);
    send_frame(0, 20, 1'b0, 220, 1'b0, 5);
    @(posedge clk); #1;
    reset_n  = 1'b0;
    tvalid_a = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("midreset_tvalid", {63'd0, m_tvalid_a}, 64'd0);
    chk("midreset_occ", {51'd0, occ_a}, 64'd0);
`ifdef ETH_RX_FIFO_STATS_EN
    chk("midreset_stats", {st_good_a, st_bad_a} | {32'd0, st_ovf_a}, 64'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_stays_empty", {50'd0, m_tvalid_a, occ_a}, 64'd0);
    send_frame(0, 8, 1'b0, 77, 1'b1, 1000);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_occ", {51'd0, occ_a}, 64'd8);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
